vga_timing_axis: RTL and testbench

- Parametrised synchronous timing counter for one VGA axis (horizontal or vertical); replaces the fixed-width, fixed-terminal-count line counter.
- Tracks the position within a scan period split into four phases: active, front porch, sync, back porch.
- Generates sync and active-video flags and a terminal-count pulse for cascading; instantiate twice (H with en=1, V with en=H tc) to form the full 640x480 timing.

---
 rtl/vga_timing_pkg.sv | 25 ++
 rtl/vga_timing_axis.sv | 114 +++++++++++
 tb/tb_vga_timing_axis.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared types and 640x480@60 timing constants for the VGA axis counters.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_e;

  // Horizontal axis, in pixel clocks.
  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

  // Vertical axis, in lines.
  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

endpackage

// File: rtl/vga_timing_axis.sv
// One VGA timing axis: position counter plus phase FSM with registered
// sync/active flags and a combinational terminal-count pulse for cascading.
// Optional coord/first outputs are built when VGA_TIMING_COORD_EN is defined.
// State table:
//   PH_ACTIVE | visible positions, active=1
//   PH_FRONT  | front porch, blanked
//   PH_SYNC   | sync pulse asserted at SYNC_POL level
//   PH_BACK   | back porch, blanked; wraps to PH_ACTIVE at TOTAL-1
module vga_timing_axis
  import vga_timing_pkg::*;
#(
  parameter int WIDTH    = 10,
  parameter int ACTIVE   = H_ACTIVE,
  parameter int FRONT    = H_FRONT,
  parameter int SYNC     = H_SYNC,
  parameter int BACK     = H_BACK,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       phase,
  output logic             sync,
  output logic             active,
  output logic             tc
`ifdef VGA_TIMING_COORD_EN
  ,
  output logic [WIDTH-1:0] coord,
  output logic             first
`endif
);

  localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;

  // Last position of each phase, fixed at elaboration.
  localparam logic [WIDTH-1:0] END_ACTIVE = WIDTH'(ACTIVE - 1);
  localparam logic [WIDTH-1:0] END_FRONT  = WIDTH'(ACTIVE + FRONT - 1);
  localparam logic [WIDTH-1:0] END_SYNC   = WIDTH'(ACTIVE + FRONT + SYNC - 1);
  localparam logic [WIDTH-1:0] END_TOTAL  = WIDTH'(TOTAL - 1);

  if (ACTIVE < 1 || FRONT < 1 || SYNC < 1 || BACK < 1) begin : g_bad_phase
    $error("vga_timing_axis: every phase length must be at least 1");
  end
  if (longint'(TOTAL - 1) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_width
    $error("vga_timing_axis: TOTAL-1 does not fit in WIDTH bits");
  end

  logic [WIDTH-1:0] count_q, count_d;
  phase_e           phase_q, phase_d;
  logic             sync_q, sync_d;
  logic             active_q, active_d;
  logic             at_end;

  assign at_end = (count_q == END_TOTAL);

  // Next position and phase; the phase moves on the last position of each phase.
  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (en) begin
      count_d = at_end ? '0 : count_q + WIDTH'(1);
      unique case (phase_q)
        PH_ACTIVE: if (count_q == END_ACTIVE) phase_d = PH_FRONT;
        PH_FRONT:  if (count_q == END_FRONT)  phase_d = PH_SYNC;
        PH_SYNC:   if (count_q == END_SYNC)   phase_d = PH_BACK;
        PH_BACK:   if (at_end)                phase_d = PH_ACTIVE;
        default:   phase_d = PH_ACTIVE;
      endcase
    end
    sync_d   = (phase_d == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    active_d = (phase_d == PH_ACTIVE);
  end

  // State register; reset overrides the enable.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      count_q  <= '0;
      phase_q  <= PH_ACTIVE;
      sync_q   <= ~SYNC_POL;
      active_q <= 1'b1;
    end else begin
      count_q  <= count_d;
      phase_q  <= phase_d;
      sync_q   <= sync_d;
      active_q <= active_d;
    end
  end

  assign count  = count_q;
  assign phase  = phase_q;
  assign sync   = sync_q;
  assign active = active_q;
  assign tc     = en & ~Reset & at_end;

`ifdef VGA_TIMING_COORD_EN
  logic [WIDTH-1:0] coord_q, coord_d;

  // Coordinate is the position inside the visible window, zero while blanked.
  always_comb begin
    coord_d = (phase_d == PH_ACTIVE) ? count_d : '0;
  end

  // Coordinate register, kept in step with count.
  always_ff @(posedge CLK) begin
    if (Reset) coord_q <= '0;
    else       coord_q <= coord_d;
  end

  assign coord = coord_q;
  assign first = (count_q == '0);
`endif

endmodule

// File: tb/tb_vga_timing_axis.sv
// Bench for vga_timing_axis: default H axis, V axis cascaded from H tc,
// V axis with a directly driven enable, and a minimal 1/1/1/1 axis.
module tb_vga_timing_axis;
  import vga_timing_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic       rst_h = 1'b0, en_h = 1'b0;
  logic [9:0] count_h, count_v, count_vd;
  logic [1:0] phase_h, phase_v, phase_vd;
  logic       sync_h, active_h, tc_h;
  logic       sync_v, active_v, tc_v;
  logic       rst_vd = 1'b0, en_vd = 1'b0;
  logic       sync_vd, active_vd, tc_vd;
  logic       rst_m = 1'b0, en_m = 1'b0;
  logic [1:0] count_m, phase_m;
  logic       sync_m, active_m, tc_m;
`ifdef VGA_TIMING_COORD_EN
  logic [9:0] coord_h, coord_v, coord_vd;
  logic [1:0] coord_m;
  logic       first_h, first_v, first_vd, first_m;
`endif

  // Reference positions, one per instance.
  int h_pos = 0, v_pos = 0, vd_pos = 0, m_pos = 0;

  vga_timing_axis u_h (
    .CLK(clk), .Reset(rst_h), .en(en_h), .count(count_h), .phase(phase_h),
    .sync(sync_h), .active(active_h), .tc(tc_h)
`ifdef VGA_TIMING_COORD_EN
    , .coord(coord_h), .first(first_h)
`endif
  );

  vga_timing_axis #(.WIDTH(10), .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC),
                    .BACK(V_BACK), .SYNC_POL(1'b0)) u_v (
    .CLK(clk), .Reset(rst_h), .en(tc_h), .count(count_v), .phase(phase_v),
    .sync(sync_v), .active(active_v), .tc(tc_v)
`ifdef VGA_TIMING_COORD_EN
    , .coord(coord_v), .first(first_v)
`endif
  );

  vga_timing_axis #(.WIDTH(10), .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC),
                    .BACK(V_BACK), .SYNC_POL(1'b0)) u_vd (
    .CLK(clk), .Reset(rst_vd), .en(en_vd), .count(count_vd), .phase(phase_vd),
    .sync(sync_vd), .active(active_vd), .tc(tc_vd)
`ifdef VGA_TIMING_COORD_EN
    , .coord(coord_vd), .first(first_vd)
`endif
  );

  vga_timing_axis #(.WIDTH(2), .ACTIVE(1), .FRONT(1), .SYNC(1), .BACK(1),
                    .SYNC_POL(1'b1)) u_m (
    .CLK(clk), .Reset(rst_m), .en(en_m), .count(count_m), .phase(phase_m),
    .sync(sync_m), .active(active_m), .tc(tc_m)
`ifdef VGA_TIMING_COORD_EN
    , .coord(coord_m), .first(first_m)
`endif
  );

  // Phase of a position, from the phase lengths alone.
  function automatic logic [1:0] exp_phase(input int p, input int a, input int f, input int s);
    if (p < a)              return 2'd0;
    else if (p < a + f)     return 2'd1;
    else if (p < a + f + s) return 2'd2;
    else                    return 2'd3;
  endfunction

  // One cycle on the H axis (and the cascaded V axis), checked against the model.
  task automatic step_h(input logic r, input logic e);
    logic       etc_h, etc_v, esync;
    logic [9:0] ec;
    logic [1:0] ep;
    @(negedge clk);
    rst_h = r; en_h = e;
    #1;
    etc_h = e && !r && (h_pos == H_TOTAL - 1);
    etc_v = etc_h && (v_pos == V_TOTAL - 1);
    checks++;
    if (tc_h !== etc_h) begin
      failures++; $display("FAIL h_tc pos=%0d got=%b exp=%b", h_pos, tc_h, etc_h);
    end
    ec = h_pos[9:0];
    checks++;
    if (count_h !== ec) begin
      failures++; $display("FAIL h_count got=%0d exp=%0d", count_h, ec);
    end
    ep = exp_phase(h_pos, H_ACTIVE, H_FRONT, H_SYNC);
    esync = !(h_pos >= H_ACTIVE + H_FRONT && h_pos < H_ACTIVE + H_FRONT + H_SYNC);
    checks++;
    if (phase_h !== ep || active_h !== (h_pos < H_ACTIVE) || sync_h !== esync) begin
      failures++;
      $display("FAIL h_flags pos=%0d phase=%0d/%0d active=%b sync=%b/%b",
               h_pos, phase_h, ep, active_h, sync_h, esync);
    end
    ec = v_pos[9:0];
    ep = exp_phase(v_pos, V_ACTIVE, V_FRONT, V_SYNC);
    esync = !(v_pos >= V_ACTIVE + V_FRONT && v_pos < V_ACTIVE + V_FRONT + V_SYNC);
    checks++;
    if (count_v !== ec || phase_v !== ep || sync_v !== esync || tc_v !== etc_v ||
        active_v !== (v_pos < V_ACTIVE)) begin
      failures++;
      $display("FAIL v_cascade line=%0d got_count=%0d phase=%0d sync=%b tc=%b exp_phase=%0d",
               v_pos, count_v, phase_v, sync_v, tc_v, ep);
    end
`ifdef VGA_TIMING_COORD_EN
    ec = (h_pos < H_ACTIVE) ? h_pos[9:0] : 10'd0;
    checks++;
    if (coord_h !== ec || first_h !== (h_pos == 0)) begin
      failures++;
      $display("FAIL h_coord pos=%0d coord=%0d exp=%0d first=%b", h_pos, coord_h, ec, first_h);
    end
`endif
    @(posedge clk);
    if (r) begin
      h_pos = 0; v_pos = 0;
    end else begin
      if (etc_h) v_pos = (v_pos + 1) % V_TOTAL;
      if (e)     h_pos = (h_pos + 1) % H_TOTAL;
    end
  endtask

  // One cycle on the directly enabled V axis.
  task automatic step_vd(input logic r, input logic e);
    logic       etc, esync;
    logic [9:0] ec;
    logic [1:0] ep;
    @(negedge clk);
    rst_vd = r; en_vd = e;
    #1;
    etc = e && !r && (vd_pos == V_TOTAL - 1);
    ec = vd_pos[9:0];
    ep = exp_phase(vd_pos, V_ACTIVE, V_FRONT, V_SYNC);
    esync = !(vd_pos == 490 || vd_pos == 491);
    checks++;
    if (count_vd !== ec || tc_vd !== etc) begin
      failures++;
      $display("FAIL vd_count got=%0d exp=%0d tc=%b exp_tc=%b", count_vd, ec, tc_vd, etc);
    end
    checks++;
    if (phase_vd !== ep || sync_vd !== esync || active_vd !== (vd_pos < V_ACTIVE)) begin
      failures++;
      $display("FAIL vd_flags line=%0d phase=%0d/%0d sync=%b/%b active=%b",
               vd_pos, phase_vd, ep, sync_vd, esync, active_vd);
    end
    @(posedge clk);
    if (r)      vd_pos = 0;
    else if (e) vd_pos = (vd_pos + 1) % V_TOTAL;
  endtask

  // One cycle on the minimal 1/1/1/1 axis with active-high sync.
  task automatic step_m(input logic r, input logic e);
    logic       etc;
    logic [1:0] ec;
    @(negedge clk);
    rst_m = r; en_m = e;
    #1;
    etc = e && !r && (m_pos == 3);
    ec = m_pos[1:0];
    checks++;
    if (count_m !== ec || tc_m !== etc) begin
      failures++;
      $display("FAIL m_count got=%0d exp=%0d tc=%b exp_tc=%b", count_m, ec, tc_m, etc);
    end
    checks++;
    if (phase_m !== ec || sync_m !== (m_pos == 2) || active_m !== (m_pos == 0)) begin
      failures++;
      $display("FAIL m_flags pos=%0d phase=%0d sync=%b active=%b", m_pos, phase_m, sync_m, active_m);
    end
    @(posedge clk);
    if (r)      m_pos = 0;
    else if (e) m_pos = (m_pos + 1) % 4;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_h = 1'b1; en_h = 1'b1; rst_vd = 1'b1; en_vd = 1'b1; rst_m = 1'b1; en_m = 1'b1;
    #1;
    checks++;
    if (tc_h !== 1'b0 || tc_v !== 1'b0 || tc_vd !== 1'b0 || tc_m !== 1'b0) begin
      failures++; $display("FAIL reset_tc got=%b%b%b%b exp=0000", tc_h, tc_v, tc_vd, tc_m);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (count_h !== 10'd0 || phase_h !== 2'd0 || active_h !== 1'b1 || sync_h !== 1'b1 || tc_h !== 1'b0) begin
      failures++;
      $display("FAIL reset_h count=%0d phase=%0d active=%b sync=%b tc=%b",
               count_h, phase_h, active_h, sync_h, tc_h);
    end
    checks++;
    if (count_m !== 2'd0 || sync_m !== 1'b0 || active_m !== 1'b1 || count_vd !== 10'd0 || count_v !== 10'd0) begin
      failures++;
      $display("FAIL reset_others m_count=%0d m_sync=%b vd=%0d v=%0d", count_m, sync_m, count_vd, count_v);
    end
    h_pos = 0; v_pos = 0; vd_pos = 0; m_pos = 0;
  endtask

  task automatic test_h_run();
    for (int i = 0; i < 1650; i++) step_h(1'b0, 1'b1);
  endtask

  task automatic test_en_toggle();
    for (int i = 0; i < 1700; i++) step_h(1'b0, (i % 2) == 0);
    for (int i = 0; i < 800; i++)  step_h(1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    while (h_pos != 700 && guard < 900) begin
      step_h(1'b0, 1'b1);
      guard++;
    end
    checks++;
    if (h_pos != 700 || phase_h !== 2'd2) begin
      failures++; $display("FAIL reach_700 got_phase=%0d exp=2 steps=%0d", phase_h, guard);
    end
    step_h(1'b1, 1'b1);
    step_h(1'b0, 1'b0);
    step_h(1'b0, 1'b1);
  endtask

  task automatic test_cascade_lines();
    for (int i = 0; i < 2500; i++) step_h(1'b0, 1'b1);
  endtask

  task automatic test_v_direct();
    for (int i = 0; i < 1300; i++) step_vd(1'b0, $urandom_range(0, 7) != 0);
    step_vd(1'b1, 1'b1);
    step_vd(1'b0, 1'b1);
  endtask

  task automatic test_min();
    for (int i = 0; i < 12; i++) step_m(1'b0, 1'b1);
    for (int i = 0; i < 30; i++) step_m(1'b0, 1'($urandom_range(0, 1)));
    step_m(1'b1, 1'b1);
    step_m(1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_h_run();
    test_en_toggle();
    test_reset_mid();
    test_cascade_lines();
    test_v_direct();
    test_min();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
